// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: transmit shift engine of a 16550-style UART.
// Pops characters from the TX FIFO (registered read port) and sends
// start bit, 5..8 data bits LSB first, optional parity and 1/1.5/2 stop
// bits, timed by the 16x baud enable.
// Optional feature macro: UART_TX_STICK_PARITY_EN (stick parity via sp).
module uart_tx_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             baud_en,
   input  logic             fifo_empty,
   input  logic [WIDTH:0]   fifo_data,
   output logic             fifo_read,
   input  logic [1:0]       wls,
   input  logic             stb,
   input  logic             pen,
   input  logic             eps,
   input  logic             sp,
   input  logic             bc,
   output logic             txd,
   output logic             busy,
   output logic             tx_empty
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t           state;
   state_t           state_nx;

   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_nx;
   logic [4:0]       tick_cnt;
   logic [4:0]       tick_nx;
   logic [4:0]       tick_last;
   logic [2:0]       bit_cnt;
   logic [2:0]       bit_nx;
   logic [2:0]       data_last;
   logic             bit_end;

   // frame format captured at LOAD so LCR writes only affect the next frame
   logic [1:0]       wls_r;
   logic             stb_r;
   logic             pen_r;
   logic             par_r;

   logic             par_x;
   logic             par_bit;
   logic             txd_r;
   logic             txd_nx;
   logic             fifo_read_nx;
   logic             unused_bits;

   // XOR of the transmitted data bits of the word arriving from the FIFO
   always_comb begin
      par_x = 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (i < (32'(wls) + 32'd5)) begin
            par_x = par_x ^ fifo_data[i];
         end
      end
   end

   // parity bit resolved at LOAD; eps/sp only matter through this value,
   // so latching the result is equivalent to latching the raw fields
`ifdef UART_TX_STICK_PARITY_EN
   always_comb begin
      if (sp) begin
         par_bit = ~eps;
      end else begin
         par_bit = eps ? par_x : ~par_x;
      end
   end
   assign unused_bits = fifo_data[WIDTH];
`else
   always_comb begin
      par_bit = eps ? par_x : ~par_x;
   end
   assign unused_bits = ^{sp, fifo_data[WIDTH]};
`endif

   // last tick index of the current bit period (stop length per frame format)
   always_comb begin
      tick_last = 5'd15;
      if (state == STOP && stb_r) begin
         tick_last = (wls_r == 2'd0) ? 5'd23 : 5'd31;
      end
   end

   assign bit_end   = baud_en && (tick_cnt == tick_last);
   assign data_last = 3'd4 + {1'b0, wls_r};

   // next-state, datapath and registered-output next values
   always_comb begin
      state_nx = state;
      shreg_nx = shreg;
      tick_nx  = tick_cnt;
      bit_nx   = bit_cnt;

      if ((state == START || state == DATA || state == PARITY || state == STOP) && baud_en) begin
         tick_nx = bit_end ? 5'd0 : tick_cnt + 5'd1;
      end

      unique case (state)
         IDLE: begin
            if (!fifo_empty) begin
               state_nx = FETCH;
            end
         end
         FETCH: begin
            state_nx = LOAD;
         end
         LOAD: begin
            shreg_nx = fifo_data[WIDTH-1:0];
            tick_nx  = '0;
            bit_nx   = '0;
            state_nx = START;
         end
         START: begin
            if (bit_end) begin
               state_nx = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               shreg_nx = shreg >> 1;
               if (bit_cnt == data_last) begin
                  state_nx = pen_r ? PARITY : STOP;
               end else begin
                  bit_nx = bit_cnt + 3'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_nx = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_nx = fifo_empty ? IDLE : FETCH;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // output register value follows the state being entered
   always_comb begin
      txd_nx = 1'b1;
      unique case (state_nx)
         START:   txd_nx = 1'b0;
         DATA:    txd_nx = shreg_nx[0];
         PARITY:  txd_nx = par_r;
         default: txd_nx = 1'b1;
      endcase
      fifo_read_nx = (state_nx == FETCH);
   end

   // state, datapath and output registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         shreg     <= '0;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         wls_r     <= '0;
         stb_r     <= 1'b0;
         pen_r     <= 1'b0;
         par_r     <= 1'b0;
         txd_r     <= 1'b1;
         fifo_read <= 1'b0;
      end else begin
         state     <= state_nx;
         shreg     <= shreg_nx;
         tick_cnt  <= tick_nx;
         bit_cnt   <= bit_nx;
         txd_r     <= txd_nx;
         fifo_read <= fifo_read_nx;
         if (state == LOAD) begin
            wls_r <= wls;
            stb_r <= stb;
            pen_r <= pen;
            par_r <= par_bit;
         end
      end
   end

   // break overrides the registered line without stopping the engine
   assign txd      = txd_r & ~bc;
   assign busy     = (state != IDLE);
   assign tx_empty = (state == IDLE) && fifo_empty;

endmodule
